cacheline_adapter: RTL and testbench

Converts one 256-bit cacheline transaction from the L1 arbiter into a four-beat, 64-bit burst on physical memory, and reassembles returned beats into a full line. It sits directly downstream of the arbiter, between the arbiter's line-wide pmem port and the core's external `mem_*` pins. It owns the burst sequencing: beat counting, line buffering, and the single-cycle completion pulse back to the arbiter.

---
 rtl/rv32i_types.sv | 18 +
 rtl/cacheline_adapter.sv | 110 +++++++++++
 tb/tb_cacheline_adapter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: line/word aliases and cacheline adapter definitions.
// Provides adapter_state_t, BURST_BEATS and BEAT_W for the burst adapter.
package rv32i_types;

    typedef logic [255:0] rv32i_line;
    typedef logic [31:0]  rv32i_word;

    localparam int BURST_BEATS = 4;
    localparam int BEAT_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Line <-> 4-beat 64-bit burst adapter between the L1 arbiter and memory.
// Ports: line_i/line_o/address_i/read_i/write_i/resp_o face the arbiter;
// burst_i/burst_o/address_o/read_o/write_o/resp_i face physical memory.
module cacheline_adapter
    import rv32i_types::*;
#(
    parameter int BEATS = BURST_BEATS
) (
    input  logic                clk,
    input  logic                rst,
    input  rv32i_line           line_i,
    output rv32i_line           line_o,
    input  rv32i_word           address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BEAT_W-1:0]   burst_i,
    output logic [BEAT_W-1:0]   burst_o,
    output rv32i_word           address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int CW = $clog2(BEATS);
    localparam rv32i_word ALIGN = 32'hFFFF_FFE0;

    adapter_state_t  state, state_d;
    logic [CW-1:0]   cnt;
    rv32i_line       line_buf;
    rv32i_line       line_q;
    rv32i_line       rd_line;
    rv32i_word       addr_q;
    logic            last;

    assign last = (cnt == CW'(BEATS - 1));

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (write_i)
                    state_d = WR;
                else if (read_i)
                    state_d = RD;
            end
            RD, WR: begin
                if (resp_i && last)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffer with the incoming beat merged in; also the completed
    // line on the final beat, so line_o is ready during DONE.
    always_comb begin
        rd_line = line_buf;
        rd_line[BEAT_W*cnt +: BEAT_W] = burst_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            line_buf <= '0;
            line_q   <= '0;
            addr_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (write_i || read_i) begin
                        addr_q <= address_i & ALIGN;
                        cnt    <= '0;
                    end
                    if (write_i)
                        line_buf <= line_i;
                end
                RD: begin
                    if (resp_i) begin
                        line_buf <= rd_line;
                        cnt      <= cnt + 1'b1;
                        if (last)
                            line_q <= rd_line;
                    end
                end
                WR: begin
                    if (resp_i)
                        cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign read_o    = (state == RD);
    assign write_o   = (state == WR);
    assign resp_o    = (state == DONE);
    assign address_o = addr_q;
    assign burst_o   = line_buf[BEAT_W*cnt +: BEAT_W];
    assign line_o    = line_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed and random bursts.
// Reference: a line is just its four beats concatenated, beat 0 lowest.
module tb_cacheline_adapter;
    import rv32i_types::*;

    logic             clk;
    logic             rst;
    rv32i_line        line_i;
    rv32i_line        line_o;
    rv32i_word        address_i;
    logic             read_i;
    logic             write_i;
    logic             resp_o;
    logic [63:0]      burst_i;
    logic [63:0]      burst_o;
    rv32i_word        address_o;
    logic             read_o;
    logic             write_o;
    logic             resp_i;

    int n_checks = 0;
    int n_fail   = 0;
    rv32i_line last_rd = '0;

    cacheline_adapter #(.BEATS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic rv32i_line rand_line();
        rv32i_line l;
        for (int i = 0; i < 8; i++)
            l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [63:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_rd"}, read_o, 1'b0);
        chk({tag, "_wr"}, write_o, 1'b0);
        chk({tag, "_resp"}, resp_o, 1'b0);
    endtask

    // One full line transaction. gap_max < 0 selects the fixed gap
    // pattern {1,2,0,2}, i.e. strobes on cycles 2, 5, 6, 9.
    task automatic run(input bit wr, input bit rd, input rv32i_word addr,
                       input rv32i_line wline, input rv32i_line rline,
                       input int gap_max, input bit hold);
        bit is_wr;
        int gap;
        int fixed_gaps [4];
        fixed_gaps = '{1, 2, 0, 2};
        is_wr = wr;
        line_i    = wline;
        address_i = addr;
        write_i   = wr;
        read_i    = rd;
        step();
        chk("acc_read_o", read_o, !is_wr);
        chk("acc_write_o", write_o, is_wr);
        chk("acc_address_o", address_o, {addr[31:5], 5'b0});
        if (!hold) begin
            read_i    = 1'b0;
            write_i   = 1'b0;
            address_i = $urandom;
            line_i    = rand_line();
        end
        for (int b = 0; b < 4; b++) begin
            gap = (gap_max < 0) ? fixed_gaps[b] : $urandom_range(0, gap_max);
            for (int g = 0; g < gap; g++) begin
                resp_i  = 1'b0;
                burst_i = rand_beat();
                step();
                chk("gap_active", is_wr ? write_o : read_o, 1'b1);
                chk("gap_resp_o", resp_o, 1'b0);
            end
            resp_i  = 1'b1;
            burst_i = rline[64*b +: 64];
            if (is_wr)
                chk("burst_o", burst_o, wline[64*b +: 64]);
            step();
            resp_i  = 1'b0;
            burst_i = rand_beat();
            if (b < 3) begin
                chk("beat_active", is_wr ? write_o : read_o, 1'b1);
                chk("beat_resp_o", resp_o, 1'b0);
            end else begin
                if (!is_wr)
                    last_rd = rline;
                chk("done_read_o", read_o, 1'b0);
                chk("done_write_o", write_o, 1'b0);
                chk("done_resp_o", resp_o, 1'b1);
                chk("done_line_o", line_o, last_rd);
            end
        end
        step();
        chk_idle_outs("after_done");
        chk("held_line_o", line_o, last_rd);
        if (hold) begin
            read_i  = 1'b0;
            write_i = 1'b0;
        end
    endtask

    rv32i_line l;

    initial begin
        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        step();
        chk_idle_outs("reset");
        chk("reset_address_o", address_o, 32'h0);
        chk("reset_burst_o", burst_o, 64'h0);
        chk("reset_line_o", line_o, 256'h0);
        rst = 1'b1;
        step();

        // Stray memory strobes while idle do nothing.
        resp_i = 1'b1;
        step();
        step();
        resp_i = 1'b0;
        chk_idle_outs("idle_resp_i");

        // Back-to-back read of the canonical test line.
        l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run(1'b0, 1'b1, 32'h0000_1234, '0, l, 0, 1'b0);
        chk("b2b_line_o", line_o, 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

        // Gapped write; line_o must keep the previous read line.
        l = rand_line();
        run(1'b1, 1'b0, 32'hDEAD_BEEF, l, rand_line(), -1, 1'b0);

        // Both requests high: write wins.
        run(1'b1, 1'b1, 32'h0000_8040, rand_line(), rand_line(), 1, 1'b0);

        // Request held across resp_o, then immediate next read.
        run(1'b0, 1'b1, 32'h1000_0000, '0, rand_line(), 0, 1'b1);
        run(1'b0, 1'b1, 32'h2000_003F, '0, rand_line(), 0, 1'b0);

        // Asynchronous reset in the middle of a read.
        read_i    = 1'b1;
        address_i = 32'hCAFE_F00D;
        step();
        read_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            resp_i  = 1'b1;
            burst_i = rand_beat();
            step();
        end
        resp_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_idle_outs("mid_rst");
        chk("mid_rst_address_o", address_o, 32'h0);
        chk("mid_rst_burst_o", burst_o, 64'h0);
        chk("mid_rst_line_o", line_o, 256'h0);
        last_rd = '0;
        step();
        rst = 1'b1;
        step();
        chk_idle_outs("post_rst");
        run(1'b0, 1'b1, 32'h0000_0100, '0, rand_line(), 0, 1'b0);

        // Random mix of reads and writes with random gaps.
        for (int t = 0; t < 20; t++) begin
            bit w;
            w = $urandom_range(0, 1);
            run(w, !w, $urandom, rand_line(), rand_line(), 3, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
